// File: rtl/uart_packet_controller.sv
// rtl/uart_packet_controller.sv - UART command decoder, accelerator supervisor and result packet framer
module uart_packet_controller #(
    parameter int          NUM_WORDS      = 2,
    parameter int          WORD_BYTES     = 4,
    parameter int          TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0]  FRAME_HDR      = 8'h5A
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    input  logic                              rx_error,
    output logic [7:0]                        tx_data,
    output logic                              tx_send,
    input  logic                              tx_busy,
    input  logic                              tx_done,
    output logic                              proc_start,
    input  logic                              proc_busy,
    input  logic                              proc_done,
    input  logic [NUM_WORDS*WORD_BYTES*8-1:0] result_data,
    output logic [7:0]                        last_command,
    output logic [7:0]                        last_response,
    output logic                              timeout_flag,
    output logic [3:0]                        state_dbg
);

    localparam int         LEN  = NUM_WORDS * WORD_BYTES;
    localparam int         DW   = LEN * 8;
    localparam int         WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0] LEN8 = 8'(LEN);

    localparam logic [7:0] CMD_PING  = 8'h50;
    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_STAT  = 8'h3F;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_ABORT = 8'h58;
    localparam logic [7:0] RSP_OK    = 8'h4F;
    localparam logic [7:0] RSP_ACK   = 8'h41;
    localparam logic [7:0] RSP_BUSY  = 8'h42;
    localparam logic [7:0] RSP_DONE  = 8'h44;
    localparam logic [7:0] RSP_TMO   = 8'h54;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        DECODE      = 4'd1,
        SEND_RSP    = 4'd2,
        WAIT_TX     = 4'd3,
        START_PROC  = 4'd4,
        SEND_PKT    = 4'd5,
        WAIT_PKT_TX = 4'd6
    } state_t;

    state_t            state, state_next;
    logic [7:0]        tx_byte;
    logic [DW-1:0]     snap;
    logic [7:0]        chk;
    logic [8:0]        byte_idx;
    logic              start_pending;
    logic              running;
    logic [WD_W-1:0]   wdog;
    logic              done_q;
    logic              done_ok;
    logic              done_edge;
    logic              abort;
    logic [7:0]        dec_rsp;
    logic              dec_pkt;
    logic              dec_start;
    logic              pkt_last;

    // A completion only counts once the accelerator has also dropped busy.
    assign done_ok   = proc_done & ~proc_busy;
    assign done_edge = done_ok & ~done_q;
    assign abort     = (state == DECODE) && (last_command == CMD_ABORT);
    assign pkt_last  = (byte_idx == 9'(LEN + 2));

    always_comb begin
        dec_rsp   = RSP_ERR;
        dec_pkt   = 1'b0;
        dec_start = 1'b0;
        case (last_command)
            CMD_PING:  dec_rsp = RSP_OK;
            CMD_START: begin
                dec_rsp   = running ? RSP_BUSY : RSP_ACK;
                dec_start = ~running;
            end
            CMD_STAT: begin
                if (timeout_flag)   dec_rsp = RSP_TMO;
                else if (running)   dec_rsp = RSP_BUSY;
                else if (proc_done) dec_rsp = RSP_DONE;
                else                dec_rsp = RSP_ACK;
            end
            CMD_READ: begin
                dec_rsp = RSP_BUSY;
                dec_pkt = proc_done & ~running;
            end
            CMD_ABORT: dec_rsp = RSP_ACK;
            default:   dec_rsp = RSP_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_error)      state_next = SEND_RSP;
                else if (rx_valid) state_next = DECODE;
            end
            DECODE:      state_next = dec_pkt ? SEND_PKT : SEND_RSP;
            SEND_RSP:    if (!tx_busy) state_next = WAIT_TX;
            WAIT_TX:     if (tx_done) state_next = start_pending ? START_PROC : IDLE;
            START_PROC:  state_next = IDLE;
            SEND_PKT:    if (!tx_busy) state_next = WAIT_PKT_TX;
            WAIT_PKT_TX: if (tx_done) state_next = pkt_last ? IDLE : SEND_PKT;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_send    = ((state == SEND_RSP) || (state == SEND_PKT)) && !tx_busy;
        proc_start = (state == START_PROC);
        tx_data    = tx_byte;
        state_dbg  = state;
    end

    // Packet bytes stream out of a snapshot shift register so later changes
    // on result_data cannot tear a packet in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_byte       <= '0;
            snap          <= '0;
            chk           <= '0;
            byte_idx      <= '0;
            start_pending <= 1'b0;
            last_command  <= '0;
            last_response <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_error) begin
                        tx_byte       <= RSP_ERR;
                        start_pending <= 1'b0;
                    end else if (rx_valid) begin
                        last_command <= rx_data;
                    end
                end
                DECODE: begin
                    if (dec_pkt) begin
                        tx_byte  <= FRAME_HDR;
                        snap     <= result_data;
                        chk      <= LEN8;
                        byte_idx <= '0;
                    end else begin
                        tx_byte <= dec_rsp;
                    end
                    start_pending <= dec_start;
                end
                SEND_RSP, SEND_PKT: begin
                    if (!tx_busy) last_response <= tx_byte;
                end
                WAIT_PKT_TX: begin
                    if (tx_done && !pkt_last) begin
                        byte_idx <= byte_idx + 9'd1;
                        if (byte_idx == 9'd0) begin
                            tx_byte <= LEN8;
                        end else if (byte_idx == 9'(LEN + 1)) begin
                            tx_byte <= chk;
                        end else begin
                            tx_byte <= snap[7:0];
                            chk     <= chk ^ snap[7:0];
                            snap    <= snap >> 8;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running      <= 1'b0;
            timeout_flag <= 1'b0;
            wdog         <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= done_ok;
            if (state == START_PROC) begin
                running      <= 1'b1;
                timeout_flag <= 1'b0;
                wdog         <= '0;
            end else if (running) begin
                if (done_edge || abort) begin
                    running <= 1'b0;
                end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_flag <= 1'b1;
                    running      <= 1'b0;
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end
        end
    end

endmodule
